// File: rtl/vx_vgpr_responder_if.sv
// Purpose: VGPR responder bus bundle: read request/response, masked writeback, init status.
// Ports:   master = operand collector / commit side, slave = register file responder.
//          req_* read request, rsp_* read response, wr_* masked writeback, busy init flag.
interface vx_vgpr_responder_if #(
  parameter int NUM_WIS    = 4,
  parameter int SIMD_COUNT = 2,
  parameter int VL_COUNT   = 4,
  parameter int NUM_VREGS  = 32,
  parameter int SIMD_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int OPD_W      = 2
);
  localparam int WIS_W = (NUM_WIS    > 1) ? $clog2(NUM_WIS)    : 1;
  localparam int SID_W = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int LID_W = (VL_COUNT   > 1) ? $clog2(VL_COUNT)   : 1;
  localparam int REG_W = $clog2(NUM_VREGS);
  localparam int ROW_W = SIMD_WIDTH * XLEN;

  logic                  req_valid;
  logic                  req_ready;
  logic [OPD_W-1:0]      req_opd_id;
  logic [WIS_W-1:0]      req_wis;
  logic [SID_W-1:0]      req_sid;
  logic [LID_W-1:0]      req_lid;
  logic [REG_W-1:0]      req_reg_id;

  logic                  rsp_valid;
  logic [OPD_W-1:0]      rsp_opd_id;
  logic [ROW_W-1:0]      rsp_data;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [WIS_W-1:0]      wr_wis;
  logic [SID_W-1:0]      wr_sid;
  logic [LID_W-1:0]      wr_lid;
  logic [REG_W-1:0]      wr_reg_id;
  logic [SIMD_WIDTH-1:0] wr_tmask;
  logic [ROW_W-1:0]      wr_data;

  logic                  busy;

  modport master (
    output req_valid, req_opd_id, req_wis, req_sid, req_lid, req_reg_id,
    output wr_valid, wr_wis, wr_sid, wr_lid, wr_reg_id, wr_tmask, wr_data,
    input  req_ready, rsp_valid, rsp_opd_id, rsp_data, wr_ready, busy
  );

  modport slave (
    input  req_valid, req_opd_id, req_wis, req_sid, req_lid, req_reg_id,
    input  wr_valid, wr_wis, wr_sid, wr_lid, wr_reg_id, wr_tmask, wr_data,
    output req_ready, rsp_valid, rsp_opd_id, rsp_data, wr_ready, busy
  );
endinterface

// File: rtl/vx_vgpr_responder.sv
// Purpose: vector register file responder, 1R1W row storage zero-filled after reset.
// Latency: read response one cycle after req fire; writes visible to reads fired the next cycle.
// Backpressure: req_ready/wr_ready low only while initialising; responses are never stalled.
// Ports: clk, reset (sync, active-high), bus (vx_vgpr_responder_if.slave).
// Option: define VGPR_BYPASS_EN to forward same-cycle same-row write data into the read response.
module vx_vgpr_responder #(
  parameter int NUM_WIS    = 4,
  parameter int SIMD_COUNT = 2,
  parameter int VL_COUNT   = 4,
  parameter int NUM_VREGS  = 32,
  parameter int SIMD_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int OPD_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_vgpr_responder_if.slave   bus
);
  localparam int WIS_W  = (NUM_WIS    > 1) ? $clog2(NUM_WIS)    : 1;
  localparam int SID_W  = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int LID_W  = (VL_COUNT   > 1) ? $clog2(VL_COUNT)   : 1;
  localparam int REG_W  = $clog2(NUM_VREGS);
  localparam int ROW_W  = SIMD_WIDTH * XLEN;
  localparam int ADDR_W = WIS_W + SID_W + LID_W + REG_W;
  localparam int DEPTH  = NUM_WIS * SIMD_COUNT * VL_COUNT * NUM_VREGS;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     init_cnt_q, init_cnt_d;

  // Stored per thread so a masked writeback touches only its enabled lanes.
  logic [XLEN-1:0]       mem_q [DEPTH][SIMD_WIDTH];

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [SIMD_WIDTH-1:0] mem_wmask;
  logic [ROW_W-1:0]      mem_wdata;

  logic [ADDR_W-1:0]     rd_addr;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  rd_fire;
  logic [ROW_W-1:0]      rd_row;

  logic                  rsp_valid_q;
  logic [OPD_W-1:0]      rsp_opd_id_q;
  logic [ROW_W-1:0]      rsp_data_q;

  assign rd_addr = {bus.req_wis, bus.req_sid, bus.req_lid, bus.req_reg_id};
  assign wr_addr = {bus.wr_wis, bus.wr_sid, bus.wr_lid, bus.wr_reg_id};
  assign rd_fire = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The single write port is shared: the zero-fill sweep owns it during INIT,
  // the commit path owns it afterwards.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    bus.req_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.busy      = 1'b1;
    mem_we        = 1'b0;
    mem_waddr     = init_cnt_q;
    mem_wmask     = '1;
    mem_wdata     = '0;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        bus.req_ready = 1'b1;
        bus.wr_ready  = 1'b1;
        bus.busy      = 1'b0;
        mem_we        = bus.wr_valid;
        mem_waddr     = wr_addr;
        mem_wmask     = bus.wr_tmask;
        mem_wdata     = bus.wr_data;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int t = 0; t < SIMD_WIDTH; t++) begin
        if (mem_wmask[t]) begin
          mem_q[mem_waddr][t] <= mem_wdata[t*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_row = '0;
    for (int t = 0; t < SIMD_WIDTH; t++) begin
      rd_row[t*XLEN +: XLEN] = mem_q[rd_addr][t];
`ifdef VGPR_BYPASS_EN
      // Same-cycle write to the row being read wins for its enabled threads.
      if (mem_we && (mem_waddr == rd_addr) && mem_wmask[t]) begin
        rd_row[t*XLEN +: XLEN] = mem_wdata[t*XLEN +: XLEN];
      end
`endif
    end
  end

  // Response payload holds between responses; reset drops any in-flight one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_opd_id_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      rsp_valid_q <= rd_fire;
      if (rd_fire) begin
        rsp_opd_id_q <= bus.req_opd_id;
        rsp_data_q   <= rd_row;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_opd_id = rsp_opd_id_q;
  assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_vx_vgpr_responder.sv
// Purpose: self-checking bench for vx_vgpr_responder (default parameters).
// Ports: none; instantiates vx_vgpr_responder_if and the DUT, drives on negedge, checks on negedge.
// Option: compile with VGPR_BYPASS_EN to expect forwarded same-cycle write data.
module tb_vx_vgpr_responder;
  localparam int DEPTH = 1024;
  localparam int ROW_W = 128;

  typedef struct {
    logic             rd;
    logic [1:0]       opd;
    logic [9:0]       raddr;
    logic             wr;
    logic [9:0]       waddr;
    logic [3:0]       tmask;
    logic [ROW_W-1:0] wdata;
    logic [ROW_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]       opd;
    logic [ROW_W-1:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   pend = 1'b0;
  sb_t  sb_q[$];
  sb_t  last_rsp;
  vec_t tbl[14];

  always #5 clk = ~clk;

  vx_vgpr_responder_if bus ();

  vx_vgpr_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [ROW_W-1:0] row(input logic [31:0] t3, input logic [31:0] t2,
                                           input logic [31:0] t1, input logic [31:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  function automatic logic [9:0] adr(input logic [1:0] wis, input logic sid,
                                     input logic [1:0] lid, input logic [4:0] rg);
    return {wis, sid, lid, rg};
  endfunction

  function automatic vec_t mk(input logic rd, input logic [1:0] opd, input logic [9:0] raddr,
                              input logic wr, input logic [9:0] waddr, input logic [3:0] tmask,
                              input logic [ROW_W-1:0] wdata, input logic [ROW_W-1:0] exp);
    vec_t v;
    v.rd = rd; v.opd = opd; v.raddr = raddr;
    v.wr = wr; v.waddr = waddr; v.tmask = tmask; v.wdata = wdata;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0; bus.req_opd_id = '0;
    {bus.req_wis, bus.req_sid, bus.req_lid, bus.req_reg_id} = 10'd0;
    bus.wr_valid = 1'b0; bus.wr_tmask = '0; bus.wr_data = '0;
    {bus.wr_wis, bus.wr_sid, bus.wr_lid, bus.wr_reg_id} = 10'd0;
  endtask

  task automatic drive(input vec_t v);
    sb_t e;
    bus.req_valid = v.rd;
    bus.req_opd_id = v.opd;
    {bus.req_wis, bus.req_sid, bus.req_lid, bus.req_reg_id} = v.raddr;
    bus.wr_valid = v.wr;
    {bus.wr_wis, bus.wr_sid, bus.wr_lid, bus.wr_reg_id} = v.waddr;
    bus.wr_tmask = v.tmask;
    bus.wr_data = v.wdata;
    if (v.rd) begin
      chk("req_ready_at_issue", 128'(bus.req_ready), 128'(1));
      e.opd = v.opd;
      e.data = v.exp;
      sb_q.push_back(e);
      pend = 1'b1;
    end
  endtask

  // One clock; on the following negedge compare any response against the scoreboard.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(pend));
    if (bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got response opd %0d with nothing outstanding", bus.rsp_opd_id);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_opd_id", 128'(bus.rsp_opd_id), 128'(e.opd));
        chk("rsp_data", bus.rsp_data, e.data);
        last_rsp = e;
      end
    end
    pend = 1'b0;
  endtask

  // Counts consecutive negedges with busy=1/req_ready=0, starting at the release negedge.
  task automatic wait_init(input string name);
    int n = 0;
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (bus.busy && !bus.req_ready) begin
        n++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk(name, 128'(n), 128'(DEPTH));
    chk({name, "_busy_after"}, 128'(bus.busy), 128'(0));
    chk({name, "_req_ready_after"}, 128'(bus.req_ready), 128'(1));
    chk({name, "_wr_ready_after"}, 128'(bus.wr_ready), 128'(1));
  endtask

  initial begin
    logic [9:0]       a_r7, b_r0, c_r31, r_z, r_a;
    logic [ROW_W-1:0] aa, byp_exp;

    a_r7  = adr(2'd0, 1'b0, 2'd3, 5'd7);
    b_r0  = adr(2'd3, 1'b1, 2'd3, 5'd0);
    c_r31 = adr(2'd3, 1'b1, 2'd3, 5'd31);
    r_z   = adr(2'd0, 1'b0, 2'd0, 5'd0);
    r_a   = adr(2'd1, 1'b0, 2'd2, 5'd5);
    aa    = row(32'hAA, 32'hAA, 32'hAA, 32'hAA);
`ifdef VGPR_BYPASS_EN
    byp_exp = aa;
`else
    byp_exp = row(32'h0, 32'h3, 32'h0, 32'h1);
`endif

    tbl[0]  = mk(1, 2'd2, r_a,   0, 10'd0, 4'b0000, '0, '0);
    tbl[1]  = mk(0, 2'd0, 10'd0, 1, a_r7, 4'b0101, row(32'h4, 32'h3, 32'h2, 32'h1), '0);
    tbl[2]  = mk(1, 2'd1, a_r7,  0, 10'd0, 4'b0000, '0, row(32'h0, 32'h3, 32'h0, 32'h1));
    tbl[3]  = mk(1, 2'd0, a_r7,  1, a_r7, 4'b1111, aa, byp_exp);
    tbl[4]  = mk(1, 2'd1, a_r7,  0, 10'd0, 4'b0000, '0, aa);
    tbl[5]  = mk(0, 2'd0, 10'd0, 1, a_r7, 4'b0000, row(32'hFF, 32'hFF, 32'hFF, 32'hFF), '0);
    tbl[6]  = mk(1, 2'd2, a_r7,  0, 10'd0, 4'b0000, '0, aa);
    tbl[7]  = mk(0, 2'd0, 10'd0, 1, b_r0, 4'b1111, row(32'h11, 32'h22, 32'h33, 32'h44), '0);
    tbl[8]  = mk(0, 2'd0, 10'd0, 1, c_r31, 4'b1000, row(32'hDEADBEEF, 32'h5, 32'h6, 32'h7), '0);
    tbl[9]  = mk(1, 2'd0, b_r0,  0, 10'd0, 4'b0000, '0, row(32'h11, 32'h22, 32'h33, 32'h44));
    tbl[10] = mk(1, 2'd1, c_r31, 0, 10'd0, 4'b0000, '0, row(32'hDEADBEEF, 32'h0, 32'h0, 32'h0));
    tbl[11] = mk(1, 2'd2, r_z,   0, 10'd0, 4'b0000, '0, '0);
    tbl[12] = mk(1, 2'd0, b_r0,  1, a_r7, 4'b0010, row(32'h0, 32'h0, 32'h55, 32'h0),
                 row(32'h11, 32'h22, 32'h33, 32'h44));
    tbl[13] = mk(1, 2'd1, a_r7,  0, 10'd0, 4'b0000, '0, row(32'hAA, 32'hAA, 32'h55, 32'hAA));

    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 128'(bus.req_ready), 128'(0));
    chk("reset_wr_ready", 128'(bus.wr_ready), 128'(0));
    chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("reset_rsp_opd_id", 128'(bus.rsp_opd_id), 128'(0));
    chk("reset_rsp_data", bus.rsp_data, '0);
    chk("reset_busy", 128'(bus.busy), 128'(1));
    reset = 1'b0;
    wait_init("init1_cycles");

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i]);
      tick();
    end
    drive_idle();
    tick();
    chk("hold_rsp_data", bus.rsp_data, last_rsp.data);
    chk("hold_rsp_opd_id", 128'(bus.rsp_opd_id), 128'(last_rsp.opd));
    chk("sb_empty_1", 128'(sb_q.size()), 128'(0));

    // Read fires on the same edge that samples reset: the response must be dropped.
    bus.req_valid = 1'b1;
    bus.req_opd_id = 2'd2;
    {bus.req_wis, bus.req_sid, bus.req_lid, bus.req_reg_id} = a_r7;
    reset = 1'b1;
    tick();
    drive_idle();
    tick();
    chk("reset2_busy", 128'(bus.busy), 128'(1));
    reset = 1'b0;
    wait_init("init2_cycles");

    drive(mk(1, 2'd0, a_r7, 0, 10'd0, 4'b0000, '0, '0));
    tick();
    drive(mk(1, 2'd1, c_r31, 0, 10'd0, 4'b0000, '0, '0));
    tick();
    drive(mk(1, 2'd2, b_r0, 0, 10'd0, 4'b0000, '0, '0));
    tick();
    drive_idle();
    tick();
    chk("sb_empty_2", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
